lsu_ctrl: RTL and testbench

- Load/store sequencer between the decode/execute datapath and a single-port 64-bit data bus.
- Takes one decoded memory operation (mem_rd_ena/mem_wr_ena plus one-hot load_info/save_info, effective address, store data).
- Runs one bus transaction with byte-lane alignment, stalls the pipeline until completion, then returns a sign/zero-extended load result.
- Flags misaligned accesses, illegal encodings and bus timeouts.

---
 rtl/lsu_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_lsu_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - load/store sequencer: lane alignment, bus handshake, timeout, load extension
module lsu_ctrl #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        mem_rd_ena,
    input  logic        mem_wr_ena,
    input  logic [6:0]  load_info,
    input  logic [3:0]  save_info,
    input  logic [63:0] addr,
    input  logic [63:0] wdata,
    output logic        stall,
    output logic        done,
    output logic        err,
    output logic [63:0] rdata,
    output logic        bus_valid,
    input  logic        bus_ready,
    output logic        bus_wr,
    output logic [63:0] bus_addr,
    output logic [7:0]  bus_wmask,
    output logic [63:0] bus_wdata,
    input  logic [63:0] bus_rdata
);

    // Counter only ever needs to reach TIMEOUT-1; keep at least one bit for TIMEOUT=1.
    localparam int            CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_cnt;
    logic [1:0]    r_size;
    logic          r_signed;
    logic [2:0]    r_off;

    logic          w_mem;
    logic          w_dec_ok;
    logic [1:0]    w_size;
    logic          w_sign;
    logic          w_misal;
    logic          w_accept;
    logic          w_reject;
    logic          w_timeout;
    logic [7:0]    w_mask;
    logic [63:0]   w_wrep;
    logic [63:0]   w_shift;
    logic [63:0]   w_ext;

    assign w_mem = req_valid & (mem_rd_ena | mem_wr_ena);

    // Decode the one-hot size field of the selected direction; any other pattern is illegal.
    always_comb begin
        w_dec_ok = 1'b0;
        w_size   = 2'd0;
        w_sign   = 1'b0;
        if (mem_wr_ena) begin
            case (save_info)
                4'b0001: begin w_dec_ok = 1'b1; w_size = 2'd0; end
                4'b0010: begin w_dec_ok = 1'b1; w_size = 2'd1; end
                4'b0100: begin w_dec_ok = 1'b1; w_size = 2'd2; end
                4'b1000: begin w_dec_ok = 1'b1; w_size = 2'd3; end
                default: w_dec_ok = 1'b0;
            endcase
        end else begin
            case (load_info)
                7'b0000001: begin w_dec_ok = 1'b1; w_size = 2'd0; w_sign = 1'b1; end
                7'b0000010: begin w_dec_ok = 1'b1; w_size = 2'd1; w_sign = 1'b1; end
                7'b0000100: begin w_dec_ok = 1'b1; w_size = 2'd2; w_sign = 1'b1; end
                7'b0001000: begin w_dec_ok = 1'b1; w_size = 2'd3; end
                7'b0010000: begin w_dec_ok = 1'b1; w_size = 2'd0; end
                7'b0100000: begin w_dec_ok = 1'b1; w_size = 2'd1; end
                7'b1000000: begin w_dec_ok = 1'b1; w_size = 2'd2; end
                default:    w_dec_ok = 1'b0;
            endcase
        end
    end

    // Natural alignment check against the decoded access size.
    always_comb begin
        case (w_size)
            2'd0:    w_misal = 1'b0;
            2'd1:    w_misal = addr[0];
            2'd2:    w_misal = |addr[1:0];
            default: w_misal = |addr[2:0];
        endcase
    end

    // Asserting both enables is illegal regardless of what the size fields say.
    assign w_accept  = w_mem & ~(mem_rd_ena & mem_wr_ena) & w_dec_ok & ~w_misal;
    assign w_reject  = w_mem & ~w_accept;
    assign w_timeout = ~bus_ready & (r_cnt == CNT_LAST);

    // Byte-lane enables and replicated store data for the 64-bit bus word.
    always_comb begin
        case (w_size)
            2'd0: begin
                w_mask = 8'h01 << addr[2:0];
                w_wrep = {8{wdata[7:0]}};
            end
            2'd1: begin
                w_mask = 8'h03 << addr[2:0];
                w_wrep = {4{wdata[15:0]}};
            end
            2'd2: begin
                w_mask = 8'h0F << addr[2:0];
                w_wrep = {2{wdata[31:0]}};
            end
            default: begin
                w_mask = 8'hFF;
                w_wrep = wdata;
            end
        endcase
    end

    // Move the addressed bytes down to bit 0, then sign- or zero-extend by access size.
    assign w_shift = bus_rdata >> {r_off, 3'b000};

    always_comb begin
        case (r_size)
            2'd0:    w_ext = r_signed ? {{56{w_shift[7]}},  w_shift[7:0]}  : {56'd0, w_shift[7:0]};
            2'd1:    w_ext = r_signed ? {{48{w_shift[15]}}, w_shift[15:0]} : {48'd0, w_shift[15:0]};
            2'd2:    w_ext = r_signed ? {{32{w_shift[31]}}, w_shift[31:0]} : {32'd0, w_shift[31:0]};
            default: w_ext = w_shift;
        endcase
    end

    // Pipeline hold: a memory op waiting in IDLE, or any cycle with the bus busy.
    assign stall = (w_mem & (r_state == S_IDLE)) | (r_state == S_REQ);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = S_REQ;
                end else if (w_reject) begin
                    w_next = S_DONE;
                end
            end
            S_REQ: begin
                if (bus_ready || w_timeout) begin
                    w_next = S_DONE;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Registered bus outputs, completion flags, load result and the timeout counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus_valid <= 1'b0;
            bus_wr    <= 1'b0;
            bus_addr  <= 64'd0;
            bus_wmask <= 8'd0;
            bus_wdata <= 64'd0;
            done      <= 1'b0;
            err       <= 1'b0;
            rdata     <= 64'd0;
            r_cnt     <= '0;
            r_size    <= 2'd0;
            r_signed  <= 1'b0;
            r_off     <= 3'd0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        bus_valid <= 1'b1;
                        bus_wr    <= mem_wr_ena;
                        bus_addr  <= {addr[63:3], 3'b000};
                        bus_wmask <= w_mask;
                        bus_wdata <= mem_wr_ena ? w_wrep : 64'd0;
                        r_size    <= w_size;
                        r_signed  <= w_sign;
                        r_off     <= addr[2:0];
                        r_cnt     <= '0;
                    end else if (w_reject) begin
                        done <= 1'b1;
                        err  <= 1'b1;
                    end
                end
                S_REQ: begin
                    if (bus_ready) begin
                        bus_valid <= 1'b0;
                        done      <= 1'b1;
                        if (!bus_wr) begin
                            rdata <= w_ext;
                        end
                    end else if (w_timeout) begin
                        bus_valid <= 1'b0;
                        done      <= 1'b1;
                        err       <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb/tb_lsu_ctrl.sv - randomized self-checking bench for lsu_ctrl against a behavioural model
module tb_lsu_ctrl;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        mem_rd_ena;
    logic        mem_wr_ena;
    logic [6:0]  load_info;
    logic [3:0]  save_info;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic        stall;
    logic        done;
    logic        err;
    logic [63:0] rdata;
    logic        bus_valid;
    logic        bus_ready;
    logic        bus_wr;
    logic [63:0] bus_addr;
    logic [7:0]  bus_wmask;
    logic [63:0] bus_wdata;
    logic [63:0] bus_rdata;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc_cnt  = 0;
    logic [63:0] exp_rdata = 64'd0;
    bit          use_fixed = 0;
    logic [63:0] fixed_rdata = 64'd0;

    lsu_ctrl #(.TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .mem_rd_ena(mem_rd_ena),
        .mem_wr_ena(mem_wr_ena),
        .load_info (load_info),
        .save_info (save_info),
        .addr      (addr),
        .wdata     (wdata),
        .stall     (stall),
        .done      (done),
        .err       (err),
        .rdata     (rdata),
        .bus_valid (bus_valid),
        .bus_ready (bus_ready),
        .bus_wr    (bus_wr),
        .bus_addr  (bus_addr),
        .bus_wmask (bus_wmask),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference decode: legality, access size in bytes, signedness.
    task automatic ref_decode(input logic rd, input logic wr, input logic [6:0] li,
                              input logic [3:0] si, input logic [63:0] a,
                              output bit ill, output int nb, output bit sgn);
        int idx;
        ill = 0; nb = 1; sgn = 0; idx = 0;
        if (rd && wr) begin
            ill = 1;
        end else if (wr) begin
            if ($countones(si) != 1) ill = 1;
            else begin
                for (int i = 0; i < 4; i++) if (si[i]) idx = i;
                nb = 1 << idx;
            end
        end else begin
            if ($countones(li) != 1) ill = 1;
            else begin
                for (int i = 0; i < 7; i++) if (li[i]) idx = i;
                nb  = (idx == 3) ? 8 : (1 << (idx % 4));
                sgn = (idx < 3);
            end
        end
        if (!ill && ((int'(a[2:0]) % nb) != 0)) ill = 1;
    endtask

    function automatic logic [63:0] extend(input logic [63:0] raw, input int off,
                                           input int nb, input bit sgn);
        logic [63:0] sh, m, v;
        sh = raw >> (8 * off);
        m  = (nb == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * nb)) - 64'd1);
        v  = sh & m;
        if (sgn && sh[8 * nb - 1]) v = v | ~m;
        return v;
    endfunction

    // Present one memory op, respond on the bus after `delay` waiting cycles, check everything.
    task automatic run_op(input logic rd, input logic wr, input logic [6:0] li,
                          input logic [3:0] si, input logic [63:0] a, input logic [63:0] wd,
                          input int delay, output int nvalid, output int start);
        bit          ill, sgn, exp_to, seen;
        int          nb, exp_vc;
        logic [63:0] cap, e_addr, e_wd;
        logic [7:0]  e_wm;
        ref_decode(rd, wr, li, si, a, ill, nb, sgn);
        exp_to = !ill && (delay >= TO);
        exp_vc = ill ? 0 : (exp_to ? TO : delay + 1);
        e_addr = {a[63:3], 3'b000};
        e_wm   = 8'((((1 << nb) - 1) << a[2:0]) & 255);
        for (int i = 0; i < 8; i++) e_wd[8*i +: 8] = wr ? wd[8*(i % nb) +: 8] : 8'h00;
        cap = 64'd0; nvalid = 0; start = -1; seen = 0;
        req_valid = 1'b1; mem_rd_ena = rd; mem_wr_ena = wr;
        load_info = li; save_info = si; addr = a; wdata = wd; bus_ready = 1'b0;
        for (int cyc = 0; cyc < 40 && !seen; cyc++) begin
            #1;
            if (done) begin
                seen = 1;
                chk("done_cycle", 64'(cyc), 64'(exp_vc + 1));
                chk("valid_in_done", bus_valid, 0);
                chk("err", err, ill || exp_to);
                if (rd && !wr && !ill && !exp_to) exp_rdata = extend(cap, int'(a[2:0]), nb, sgn);
                chk("rdata", rdata, exp_rdata);
                chk("stall_done", stall, 0);
                req_valid = 1'b0; bus_ready = 1'b0;
            end else begin
                chk("stall_busy", stall, 1);
                chk("bus_valid", bus_valid, cyc > 0);
                if (bus_valid) begin
                    nvalid++;
                    if (nvalid == 1) start = cyc_cnt;
                    chk("bus_addr", bus_addr, e_addr);
                    chk("bus_wmask", bus_wmask, e_wm);
                    chk("bus_wdata", bus_wdata, e_wd);
                    chk("bus_wr", bus_wr, wr);
                    bus_ready = (nvalid > delay);
                    bus_rdata = use_fixed ? fixed_rdata : {$urandom, $urandom};
                    if (bus_ready) cap = bus_rdata;
                end else begin
                    bus_ready = 1'b0;
                end
            end
            @(negedge clk);
        end
        if (!seen) chk("done_never_seen", 0, 1);
        chk("valid_count", 64'(nvalid), 64'(exp_vc));
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            req_valid = 1'($urandom_range(0, 1));
            mem_rd_ena = 1'b0; mem_wr_ena = 1'b0;
            load_info = 7'($urandom); save_info = 4'($urandom);
            #1;
            chk("idle_stall", stall, 0);
            chk("idle_valid", bus_valid, 0);
            chk("idle_done", done, 0);
            @(negedge clk);
        end
        req_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not end");
        $fatal(1);
    end

    initial begin
        int nv, st, st2, r, delay;
        logic rd, wr;
        logic [6:0] li;
        logic [3:0] si;
        logic [63:0] a;

        rst = 1'b1; req_valid = 1'b0; mem_rd_ena = 1'b0; mem_wr_ena = 1'b0;
        load_info = 7'd0; save_info = 4'd0; addr = 64'd0; wdata = 64'd0;
        bus_ready = 1'b0; bus_rdata = 64'd0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_valid", bus_valid, 0);
        chk("rst_wr", bus_wr, 0);
        chk("rst_addr", bus_addr, 0);
        chk("rst_wmask", bus_wmask, 0);
        chk("rst_wdata", bus_wdata, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_stall", stall, 0);
        rst = 1'b0;
        @(negedge clk);

        // lb / lbu from byte 3
        use_fixed = 1; fixed_rdata = 64'h1122_3344_8566_7788;
        run_op(1, 0, 7'b0000001, 4'd0, 64'h8000_0003, 64'd0, 0, nv, st);
        chk("tp_lb", rdata, 64'hFFFF_FFFF_FFFF_FF85);
        run_op(1, 0, 7'b0010000, 4'd0, 64'h8000_0003, 64'd0, 0, nv, st);
        chk("tp_lbu", rdata, 64'h85);

        // sw with 3 wait cycles (ready arrives on the last allowed cycle)
        run_op(0, 1, 7'd0, 4'b0100, 64'h8000_0104, 64'h0123_4567_DEAD_BEEF, 3, nv, st);
        chk("tp_sw_valid", 64'(nv), 4);

        // misaligned lw, illegal encodings
        run_op(1, 0, 7'b0000100, 4'd0, 64'h8000_0002, 64'd0, 0, nv, st);
        chk("tp_lw_mis", 64'(nv), 0);
        run_op(1, 1, 7'b0000001, 4'b0001, 64'h8000_0000, 64'd0, 0, nv, st);
        run_op(1, 0, 7'b0000011, 4'd0, 64'h8000_0000, 64'd0, 0, nv, st);
        run_op(1, 0, 7'b0000000, 4'd0, 64'h8000_0000, 64'd0, 0, nv, st);
        run_op(0, 1, 7'd0, 4'b0011, 64'h8000_0000, 64'd0, 0, nv, st);
        run_op(0, 1, 7'd0, 4'b1000, 64'h8000_0004, 64'd0, 0, nv, st);
        run_op(0, 1, 7'd0, 4'b0010, 64'h8000_0001, 64'd0, 0, nv, st);

        // timeout on ld
        run_op(1, 0, 7'b0001000, 4'd0, 64'h8000_0008, 64'd0, 10, nv, st);
        chk("tp_timeout_valid", 64'(nv), 4);

        // reset in the second REQ cycle of a store
        req_valid = 1'b1; mem_rd_ena = 1'b0; mem_wr_ena = 1'b1;
        save_info = 4'b0100; addr = 64'h8000_0200; wdata = 64'h55; bus_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("pre_rst_valid", bus_valid, 1);
        rst = 1'b1; req_valid = 1'b0; mem_wr_ena = 1'b0;
        @(negedge clk);
        #1;
        chk("mid_rst_valid", bus_valid, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_stall", stall, 0);
        rst = 1'b0; exp_rdata = 64'd0;
        @(negedge clk);
        fixed_rdata = 64'hBEEF_1234_5678_9ABC;
        run_op(1, 0, 7'b0100000, 4'd0, 64'h8000_0006, 64'd0, 0, nv, st);
        chk("tp_lhu", rdata, 64'hBEEF);

        // back-to-back sd then ld
        run_op(0, 1, 7'd0, 4'b1000, 64'h8000_0010, 64'hA5A5_0F0F_1234_5678, 0, nv, st);
        run_op(1, 0, 7'b0001000, 4'd0, 64'h8000_0010, 64'd0, 0, nv, st2);
        chk("b2b_spacing", 64'(st2 - st), 3);
        use_fixed = 0;

        // random mix
        for (int k = 0; k < 150; k++) begin
            r = $urandom_range(0, 99);
            li = 7'd0; si = 4'd0; rd = 0; wr = 0;
            if (r < 45) begin
                rd = 1; li = 7'(1 << $urandom_range(0, 6));
            end else if (r < 90) begin
                wr = 1; si = 4'(1 << $urandom_range(0, 3));
            end else begin
                rd = 1'($urandom_range(0, 1)); wr = ~rd | 1'($urandom_range(0, 1));
                li = 7'($urandom); si = 4'($urandom);
            end
            a = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 0) a[2:0] = 3'd0;
            delay = $urandom_range(0, 5);
            run_op(rd, wr, li, si, a, {$urandom, $urandom}, delay, nv, st);
            if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
